// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port system memory: CPU has default priority,
// debug wins while the CPU is halted or once it has waited MAX_WAIT cycles.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_halt,
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_wdata,
  output logic              o_c_gnt,
  output logic              o_c_rvalid,
  output logic [DATA_W-1:0] o_c_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_d_starved
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  // Read-return owner: which port receives i_mem_rdata this cycle.
  typedef enum logic [1:0] {StIdle, StRetC, StRetD} state_e;

  state_e     r_state, w_state_nxt;
  logic [3:0] r_wait_cnt, w_wait_cnt_nxt;
  logic       r_d_starved;
  logic       w_d_force;
  logic       w_c_gnt;
  logic       w_d_gnt;

  assign w_d_force = i_cpu_halt | (r_wait_cnt == MaxWait);
  assign w_d_gnt   = !i_reset & i_d_req & (w_d_force | !i_c_req);
  assign w_c_gnt   = !i_reset & i_c_req & !(i_d_req & w_d_force);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_wait_cnt  <= 4'd0;
      r_d_starved <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_d_starved <= (w_wait_cnt_nxt == MaxWait);
    end
  end

  // Next state depends only on this cycle's grant, never on the current owner.
  always_comb begin
    w_state_nxt = StIdle;
    if (w_c_gnt && !i_c_we) begin
      w_state_nxt = StRetC;
    end else if (w_d_gnt && !i_d_we) begin
      w_state_nxt = StRetD;
    end

    w_wait_cnt_nxt = 4'd0;
    if (i_d_req && !w_d_gnt) begin
      w_wait_cnt_nxt = (r_wait_cnt == MaxWait) ? r_wait_cnt : r_wait_cnt + 4'd1;
    end
  end

  // Outputs; a return landing in a reset cycle is squashed.
  always_comb begin
    o_c_gnt     = w_c_gnt;
    o_d_gnt     = w_d_gnt;
    o_d_starved = r_d_starved;
    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_wdata = '0;
    if (w_c_gnt) begin
      o_mem_addr  = i_c_addr;
      o_mem_we    = i_c_we;
      o_mem_wdata = i_c_wdata;
    end else if (w_d_gnt) begin
      o_mem_addr  = i_d_addr;
      o_mem_we    = i_d_we;
      o_mem_wdata = i_d_wdata;
    end

    o_c_rvalid = 1'b0;
    o_d_rvalid = 1'b0;
    o_c_rdata  = '0;
    o_d_rdata  = '0;
    unique case (r_state)
      StRetC: begin
        o_c_rvalid = !i_reset;
        o_c_rdata  = i_reset ? '0 : i_mem_rdata;
      end
      StRetD: begin
        o_d_rvalid = !i_reset;
        o_d_rdata  = i_reset ? '0 : i_mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 256x8 synchronous-read memory model.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_halt;
  logic       c_req, c_we, c_gnt, c_rvalid;
  logic [7:0] c_addr, c_wdata, c_rdata;
  logic       d_req, d_we, d_gnt, d_rvalid;
  logic [7:0] d_addr, d_wdata, d_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
  logic       d_starved;

  logic [7:0] mem [256];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  mem_arbiter #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .MAX_WAIT(4)
  ) u_dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_cpu_halt (cpu_halt),
    .i_c_req    (c_req),
    .i_c_we     (c_we),
    .i_c_addr   (c_addr),
    .i_c_wdata  (c_wdata),
    .o_c_gnt    (c_gnt),
    .o_c_rvalid (c_rvalid),
    .o_c_rdata  (c_rdata),
    .i_d_req    (d_req),
    .i_d_we     (d_we),
    .i_d_addr   (d_addr),
    .i_d_wdata  (d_wdata),
    .o_d_gnt    (d_gnt),
    .o_d_rvalid (d_rvalid),
    .o_d_rdata  (d_rdata),
    .o_mem_addr (mem_addr),
    .o_mem_we   (mem_we),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .o_d_starved(d_starved)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cpu_halt = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = 8'h00; c_wdata = 8'h00;
    d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
  endtask

  task automatic dbg_write(input logic [7:0] a, input logic [7:0] d);
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = d;
    #1;
    check("pre_d_gnt", 16'(d_gnt), 16'd1);
    step();
    idle_in();
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    step();
    c_req = 1'b1; d_req = 1'b1;
    #1;
    check("rst_c_gnt", 16'(c_gnt), 16'd0);
    check("rst_d_gnt", 16'(d_gnt), 16'd0);
    step();
    reset = 1'b0;
    idle_in();
    #1;
    check("rst_c_rvalid", 16'(c_rvalid), 16'd0);
    check("rst_d_rvalid", 16'(d_rvalid), 16'd0);
    check("rst_starved",  16'(d_starved), 16'd0);
    check("rst_mem_we",   16'(mem_we), 16'd0);
    step();

    dbg_write(8'h10, 8'hA5);
    dbg_write(8'h01, 8'h11);
    dbg_write(8'h02, 8'h22);

    // Lone CPU read
    c_req = 1'b1; c_addr = 8'h10;
    #1;
    check("t1_c_gnt",    16'(c_gnt), 16'd1);
    check("t1_d_gnt",    16'(d_gnt), 16'd0);
    check("t1_mem_addr", 16'(mem_addr), 16'h10);
    check("t1_mem_we",   16'(mem_we), 16'd0);
    step();
    idle_in();
    #1;
    check("t1_c_rvalid", 16'(c_rvalid), 16'd1);
    check("t1_c_rdata",  16'(c_rdata), 16'hA5);
    check("t1_d_rvalid", 16'(d_rvalid), 16'd0);
    check("t1_d_rdata",  16'(d_rdata), 16'h00);
    step();

    // Idle cycles
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_mem_we",   16'(mem_we), 16'd0);
      check("t6_mem_addr", 16'(mem_addr), 16'h00);
      check("t6_gnts",     16'({c_gnt, d_gnt}), 16'd0);
      check("t6_rvalids",  16'({c_rvalid, d_rvalid}), 16'd0);
      check("t6_starved",  16'(d_starved), 16'd0);
      step();
    end

    // Both requesting: 4 CPU grants then one aged debug grant
    c_req = 1'b1; c_addr = 8'h10;
    d_req = 1'b1; d_addr = 8'h02;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("t2_c_gnt",   16'(c_gnt), (k % 5 != 4) ? 16'd1 : 16'd0);
      check("t2_d_gnt",   16'(d_gnt), (k % 5 == 4) ? 16'd1 : 16'd0);
      check("t2_starved", 16'(d_starved), (k % 5 == 4) ? 16'd1 : 16'd0);
      check("t2_c_rvalid", 16'(c_rvalid), (k > 0 && (k - 1) % 5 != 4) ? 16'd1 : 16'd0);
      check("t2_d_rvalid", 16'(d_rvalid), (k > 0 && (k - 1) % 5 == 4) ? 16'd1 : 16'd0);
      if (k > 0 && (k - 1) % 5 == 4) check("t2_d_rdata", 16'(d_rdata), 16'h22);
      if (k > 0 && (k - 1) % 5 != 4) check("t2_c_rdata", 16'(c_rdata), 16'hA5);
      step();
    end
    idle_in();
    #1;
    check("t2_last_d_rvalid", 16'(d_rvalid), 16'd1);
    check("t2_last_d_rdata",  16'(d_rdata), 16'h22);
    check("t2_last_starved",  16'(d_starved), 16'd0);
    step();

    // Halted CPU: debug write wins, then CPU reads it back
    cpu_halt = 1'b1;
    c_req = 1'b1; c_addr = 8'h20;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h3C;
    #1;
    check("t3_d_gnt",     16'(d_gnt), 16'd1);
    check("t3_c_gnt",     16'(c_gnt), 16'd0);
    check("t3_mem_we",    16'(mem_we), 16'd1);
    check("t3_mem_addr",  16'(mem_addr), 16'h20);
    check("t3_mem_wdata", 16'(mem_wdata), 16'h3C);
    step();
    cpu_halt = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    check("t3_c_gnt2",   16'(c_gnt), 16'd1);
    check("t3_no_rvalid", 16'({c_rvalid, d_rvalid}), 16'd0);
    step();
    idle_in();
    #1;
    check("t3_c_rvalid", 16'(c_rvalid), 16'd1);
    check("t3_c_rdata",  16'(c_rdata), 16'h3C);
    step();

    // Alternating owners, no bubble between returns
    c_req = 1'b1; c_addr = 8'h01;
    #1;
    check("t4_c_gnt_a", 16'(c_gnt), 16'd1);
    step();
    c_req = 1'b0; d_req = 1'b1; d_addr = 8'h02;
    #1;
    check("t4_d_gnt_b",    16'(d_gnt), 16'd1);
    check("t4_c_rvalid_b", 16'(c_rvalid), 16'd1);
    check("t4_c_rdata_b",  16'(c_rdata), 16'h11);
    step();
    d_req = 1'b0; c_req = 1'b1; c_addr = 8'h01;
    #1;
    check("t4_c_gnt_c",    16'(c_gnt), 16'd1);
    check("t4_d_rvalid_c", 16'(d_rvalid), 16'd1);
    check("t4_d_rdata_c",  16'(d_rdata), 16'h22);
    check("t4_c_rvalid_c", 16'(c_rvalid), 16'd0);
    check("t4_c_rdata_c",  16'(c_rdata), 16'h00);
    step();
    idle_in();
    #1;
    check("t4_c_rvalid_d", 16'(c_rvalid), 16'd1);
    check("t4_c_rdata_d",  16'(c_rdata), 16'h11);
    step();

    // Debug read squashed by reset; counter restarts from zero
    d_req = 1'b1; d_addr = 8'h02;
    #1;
    check("t5_d_gnt", 16'(d_gnt), 16'd1);
    step();
    reset = 1'b1;
    c_req = 1'b1; c_addr = 8'h01;
    #1;
    check("t5_squash_rvalid", 16'(d_rvalid), 16'd0);
    check("t5_squash_rdata",  16'(d_rdata), 16'h00);
    check("t5_rst_gnts",      16'({c_gnt, d_gnt}), 16'd0);
    step();
    #1;
    check("t5_rst_gnts2",   16'({c_gnt, d_gnt}), 16'd0);
    check("t5_rst_rvalids", 16'({c_rvalid, d_rvalid}), 16'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t5_c_gnt",   16'(c_gnt), (k < 4) ? 16'd1 : 16'd0);
      check("t5_d_gnt",   16'(d_gnt), (k == 4) ? 16'd1 : 16'd0);
      check("t5_starved", 16'(d_starved), (k == 4) ? 16'd1 : 16'd0);
      if (k == 0) check("t5_rel_rvalids", 16'({c_rvalid, d_rvalid}), 16'd0);
      step();
    end
    idle_in();
    #1;
    check("t5_d_rvalid", 16'(d_rvalid), 16'd1);
    check("t5_d_rdata",  16'(d_rdata), 16'h22);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
